// File: rtl/zxbus_int_ctrl_if.sv
// ZXiznet interrupt-sequencer signal bundle: source lines, #83AB enable bits,
// Z80 acknowledge strobe and the resulting interrupt outputs.
interface zxbus_int_ctrl_if;
    logic       w5300_int_n;
    logic       sl811_intrq;
    logic       ena_w5300_int;
    logic       ena_sl811_int;
    logic       ena_zxbus_int;
    logic       intack;
    logic       internal_int;
    logic       zx_int_n;
    logic [1:0] int_src;
    logic       busy;

    modport slave (
        input  w5300_int_n, sl811_intrq,
        input  ena_w5300_int, ena_sl811_int, ena_zxbus_int,
        input  intack,
        output internal_int, zx_int_n, int_src, busy
    );

    modport master (
        output w5300_int_n, sl811_intrq,
        output ena_w5300_int, ena_sl811_int, ena_zxbus_int,
        output intack,
        input  internal_int, zx_int_n, int_src, busy
    );
endinterface

// File: rtl/zxbus_int_ctrl.sv
// ZXiznet interrupt sequencer: synchronises and masks the W5300/SL811 requests
// and drives ZX-bus /INT as acknowledge-terminated pulses with a re-arm hold-off.
module zxbus_int_ctrl #(
    parameter int unsigned INT_LEN = 32,
    parameter int unsigned HOLDOFF = 1024
) (
    input  logic           clk,
    input  logic           rst,
    zxbus_int_ctrl_if.slave bus
);

    localparam int unsigned MAX_LEN = (INT_LEN > HOLDOFF) ? INT_LEN : HOLDOFF;
    localparam int unsigned CW      = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    logic [1:0]    sw_sync;
    logic [1:0]    ss_sync;
    logic          sw;
    logic          ss;
    logic          internal_int_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zx_int_n_q, zx_int_n_d;
    logic [1:0]    int_src_q, int_src_d;
    logic          busy_q;

    assign sw = sw_sync[1];
    assign ss = ss_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync        <= '0;
            ss_sync        <= '0;
            internal_int_q <= 1'b0;
        end else begin
            sw_sync        <= {sw_sync[0], ~bus.w5300_int_n};
            ss_sync        <= {ss_sync[0], bus.sl811_intrq};
            internal_int_q <= (sw & bus.ena_w5300_int) | (ss & bus.ena_sl811_int);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        zx_int_n_d = zx_int_n_q;
        int_src_d  = int_src_q;
        case (state_q)
            S_IDLE: begin
                zx_int_n_d = 1'b1;
                if (internal_int_q && bus.ena_zxbus_int) begin
                    state_d    = S_PULSE;
                    zx_int_n_d = 1'b0;
                    cnt_d      = CW'(INT_LEN - 1);
                    int_src_d  = {ss & bus.ena_sl811_int, sw & bus.ena_w5300_int};
                end
            end
            S_PULSE: begin
                // Disabling aborts straight to IDLE; acknowledge or timeout earns a hold-off.
                if (!bus.ena_zxbus_int) begin
                    state_d    = S_IDLE;
                    zx_int_n_d = 1'b1;
                end else if (bus.intack || cnt_q == '0) begin
                    state_d    = S_HOLDOFF;
                    zx_int_n_d = 1'b1;
                    cnt_d      = CW'(HOLDOFF - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLDOFF: begin
                zx_int_n_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                zx_int_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            zx_int_n_q <= 1'b1;
            int_src_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zx_int_n_q <= zx_int_n_d;
            int_src_q  <= int_src_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign bus.internal_int = internal_int_q;
    assign bus.zx_int_n     = zx_int_n_q;
    assign bus.int_src      = int_src_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_zxbus_int_ctrl.sv
// Directed bench for zxbus_int_ctrl: reset, pulse timing, re-pulse, acknowledge,
// masking, both sources and reset mid-pulse, with hand-computed expectations.
module tb_zxbus_int_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   len;
    int   lows;

    zxbus_int_ctrl_if bus ();

    zxbus_int_ctrl #(
        .INT_LEN (32),
        .HOLDOFF (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles zx_int_n stays at lvl, counted from the current sample point.
    task automatic measure(input logic lvl, input int limit, output int n);
        n = 0;
        while (bus.zx_int_n == lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic idle_inputs();
        bus.w5300_int_n   = 1'b1;
        bus.sl811_intrq   = 1'b0;
        bus.ena_w5300_int = 1'b0;
        bus.ena_sl811_int = 1'b0;
        bus.ena_zxbus_int = 1'b0;
        bus.intack        = 1'b0;
    endtask

    task automatic clean_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        idle_inputs();
        tick();

        // Reset with every input active
        bus.w5300_int_n   = 1'b0;
        bus.sl811_intrq   = 1'b1;
        bus.ena_w5300_int = 1'b1;
        bus.ena_sl811_int = 1'b1;
        bus.ena_zxbus_int = 1'b1;
        bus.intack        = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_zx_int_n", bus.zx_int_n, 1);
            check("rst_internal_int", bus.internal_int, 0);
            check("rst_int_src", bus.int_src, 0);
            check("rst_busy", bus.busy, 0);
        end
        rst = 1'b0;
        bus.intack = 1'b0;
        tick();
        check("post_rst_zx_int_n", bus.zx_int_n, 1);
        check("post_rst_internal_int", bus.internal_int, 0);
        check("post_rst_int_src", bus.int_src, 0);
        check("post_rst_busy", bus.busy, 0);

        // Single W5300 pulse
        clean_reset();
        bus.ena_w5300_int = 1'b1;
        bus.ena_zxbus_int = 1'b1;
        bus.w5300_int_n   = 1'b0;
        tick();
        check("single_e1_internal", bus.internal_int, 0);
        tick();
        check("single_e2_internal", bus.internal_int, 0);
        tick();
        check("single_e3_internal", bus.internal_int, 1);
        check("single_e3_zx", bus.zx_int_n, 1);
        tick();
        check("single_e4_zx", bus.zx_int_n, 0);
        check("single_int_src", bus.int_src, 2'b01);
        check("single_busy", bus.busy, 1);
        lows = 1;
        for (int e = 5; e <= 40; e++) begin
            if (e == 11) bus.w5300_int_n = 1'b1;
            tick();
            if (!bus.zx_int_n) lows++;
        end
        check("single_pulse_len", lows, 32);
        check("single_src_frozen", bus.int_src, 2'b01);
        check("single_internal_dropped", bus.internal_int, 0);
        lows = 0;
        for (int e = 0; e < 1100; e++) begin
            tick();
            if (!bus.zx_int_n) lows++;
        end
        check("single_no_repulse", lows, 0);
        check("single_busy_end", bus.busy, 0);

        // Pending SL811 request re-pulses
        clean_reset();
        bus.sl811_intrq   = 1'b1;
        bus.ena_sl811_int = 1'b1;
        bus.ena_zxbus_int = 1'b1;
        measure(1'b1, 20, len);
        check("pend_first_delay", len, 4);
        check("pend_int_src", bus.int_src, 2'b10);
        measure(1'b0, 100, len);
        check("pend_low1", len, 32);
        measure(1'b1, 2000, len);
        check("pend_high1", len, 1025);
        check("pend_int_src2", bus.int_src, 2'b10);
        measure(1'b0, 100, len);
        check("pend_low2", len, 32);
        measure(1'b1, 2000, len);
        check("pend_high2", len, 1025);

        // Acknowledge in the 5th low cycle of the third pulse
        check("ack_start_low", bus.zx_int_n, 0);
        for (int i = 0; i < 4; i++) tick();
        check("ack_5th_low", bus.zx_int_n, 0);
        bus.intack = 1'b1;
        tick();
        bus.intack = 1'b0;
        check("ack_zx_high", bus.zx_int_n, 1);
        check("ack_busy", bus.busy, 1);
        len = 0;
        while (bus.busy && len < 2000) begin
            tick();
            len++;
        end
        check("ack_holdoff_len", len, 1024);

        // Masking
        clean_reset();
        bus.ena_zxbus_int = 1'b1;
        bus.w5300_int_n   = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.zx_int_n) lows++;
        end
        check("mask_w_internal", bus.internal_int, 0);
        check("mask_w_no_pulse", lows, 0);
        bus.ena_zxbus_int = 1'b0;
        bus.ena_w5300_int = 1'b1;
        tick();
        check("mask_en_latency", bus.internal_int, 1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.zx_int_n) lows++;
        end
        check("mask_zx_disabled", lows, 0);
        check("mask_zx_disabled_busy", bus.busy, 0);
        bus.ena_zxbus_int = 1'b1;
        measure(1'b1, 20, len);
        check("mask_zx_enable_delay", len, 1);
        for (int i = 0; i < 3; i++) tick();
        bus.ena_zxbus_int = 1'b0;
        tick();
        check("abort_zx_high", bus.zx_int_n, 1);
        check("abort_busy", bus.busy, 0);

        // Both sources, then reset mid-pulse
        clean_reset();
        bus.w5300_int_n   = 1'b0;
        bus.sl811_intrq   = 1'b1;
        bus.ena_w5300_int = 1'b1;
        bus.ena_sl811_int = 1'b1;
        bus.ena_zxbus_int = 1'b1;
        measure(1'b1, 20, len);
        check("both_delay", len, 4);
        check("both_int_src", bus.int_src, 2'b11);
        for (int i = 0; i < 9; i++) tick();
        check("both_10th_low", bus.zx_int_n, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_zx_high", bus.zx_int_n, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_int_src", bus.int_src, 0);
        measure(1'b1, 20, len);
        check("midrst_restart_delay", len, 4);
        check("midrst_restart_src", bus.int_src, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zxbus_int_ctrl.md
Name: zxbus_int_ctrl

Overview:
- Interrupt sequencer for the ZXiznet card.
- Synchronises the W5300 and SL811 interrupt lines into the card clock and masks them with the enable bits from the #83AB control register.
- Produces the level `internal_int` that the #83AB read-back reports.
- When ZX-bus interrupts are enabled, drives the Z80 /INT line as timed, acknowledge-terminated pulses, re-armed after a hold-off while the request stays pending.

Parameters:
- INT_LEN, 32: /INT pulse length in clk cycles; must be ≥1.
- HOLDOFF, 1024: minimum /INT-inactive gap in clk cycles before a re-pulse; must be ≥1.

Ports:
- clk  input  1  card clock
- rst  input  1  synchronous reset, active-high
- w5300_int_n  input  1  W5300 interrupt, active-low, asynchronous
- sl811_intrq  input  1  SL811 interrupt, active-high, asynchronous
- ena_w5300_int  input  1  enable for the W5300 source (from #83AB bit 2)
- ena_sl811_int  input  1  enable for the SL811 source (from #83AB bit 3)
- ena_zxbus_int  input  1  enable for ZX-bus /INT generation (from #83AB bit 7)
- intack  input  1  one-cycle strobe, already synchronous to clk, marking a Z80 interrupt-acknowledge cycle
- internal_int  output  1  registered OR of enabled, synchronised sources
- zx_int_n  output  1  ZX-bus /INT, active-low, registered
- int_src  output  2  {sl811, w5300} masked source snapshot taken at pulse start
- busy  output  1  high in the PULSE or HOLDOFF state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all sync flops 0 (inactive); internal_int=0; zx_int_n=1; int_src=2'b00; busy=0; state=IDLE; counter=0.
- Synchronisers: two-flop chains on ~w5300_int_n and on sl811_intrq, producing sw and ss.
- internal_int register: internal_int <= (sw & ena_w5300_int) | (ss & ena_sl811_int).
  - Latency from an asynchronous input change to internal_int is 3 rising edges.
  - A change of an enable bit reaches internal_int after 1 edge.
- Counter: a single down-counter, width clog2(max(INT_LEN,HOLDOFF))+1, shared by PULSE and HOLDOFF.
- FSM states: IDLE, PULSE, HOLDOFF.
- IDLE:
  - zx_int_n=1, busy=0.
  - If internal_int & ena_zxbus_int: go to PULSE, set zx_int_n<=0, load counter INT_LEN-1, load int_src <= {ss&ena_sl811_int, sw&ena_w5300_int}.
- PULSE:
  - Priority 1: if !ena_zxbus_int, go to IDLE and set zx_int_n<=1 (abort, no hold-off).
  - Priority 2: if intack, or counter==0, go to HOLDOFF, set zx_int_n<=1, load counter HOLDOFF-1.
  - Otherwise decrement the counter.
  - The pulse therefore lasts exactly INT_LEN cycles unless shortened by intack or the enable.
  - intack in the same cycle as counter==0 is treated as a single exit.
- HOLDOFF:
  - zx_int_n=1.
  - When counter==0, go to IDLE; otherwise decrement.
  - Clearing ena_zxbus_int does not shorten HOLDOFF.
- Re-pulse rule: a still-pending request re-asserts /INT after HOLDOFF+1 high cycles (HOLDOFF cycles, plus one IDLE evaluation cycle).
- Source changes mid-operation:
  - A source deasserting during PULSE does not end the pulse.
  - int_src stays frozen until the next PULSE entry.
- intack in IDLE or HOLDOFF: ignored.
- busy = (state != IDLE), registered and consistent with state.
- Reset mid-pulse: on the next edge zx_int_n=1 and state=IDLE, with no hold-off applied.
- Both sources active: int_src=2'b11. There is no priority between sources; software reads int_src and the #83AB status to decide.

Test Plan:
- Reset: hold rst for 3 cycles with all inputs active → zx_int_n=1, internal_int=0, int_src=00, busy=0 throughout reset and 1 cycle after.
- Single pulse:
  - Stimulus: ena_w5300_int=1, ena_zxbus_int=1; drive w5300_int_n low at cycle 0 and release it at cycle 10.
  - Required: internal_int=1 at edge 3; zx_int_n low for exactly 32 cycles starting at edge 4; int_src=01; no re-pulse after the 1024-cycle hold-off.
- Pending re-pulse:
  - Stimulus: sl811_intrq held high, ena_sl811_int=1, ena_zxbus_int=1.
  - Required: /INT low 32 cycles, high 1025 cycles, low 32 cycles, repeating; int_src=10.
- Acknowledge: intack pulsed in the 5th low cycle of a pulse → zx_int_n=1 on the next edge; busy stays 1 for 1024 more cycles.
- Masking:
  - ena_w5300_int=0 with w5300_int_n low → internal_int=0, zx_int_n=1.
  - ena_zxbus_int=0 with a pending source → internal_int=1 while zx_int_n stays 1.
  - ena_zxbus_int cleared mid-pulse → zx_int_n=1 on the next edge; busy=0.
- Both sources, plus reset mid-pulse:
  - Both sources active → int_src=11.
  - rst asserted in the 10th low cycle → zx_int_n=1 at the next edge.
  - After rst is released with sources still active → a new pulse begins 4 edges later (3-edge internal_int latency plus 1).
